// File: rtl/adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_pkg: shared state encodings and sizing helper for the adders |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Ceiling log2, never less than 1 so a single-chunk counter still has a bit.
  function automatic int clog2_min1(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | chunk_adder: combinational CHUNK-bit ripple adder                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module chunk_adder #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_chunk_adder: A + B + Cin over WIDTH/CHUNK cycles, LSB first |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module serial_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);

  localparam int N  = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CW = clog2_min1(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic [WIDTH-1:0] res_next;

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (op_a[CHUNK-1:0]),
    .b    (op_b[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the top; after N shifts the result is fully aligned.
  assign res_next = WIDTH'({chunk_sum, res_sh} >> CHUNK);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      res_sh  <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      Sum     <= '0;
      Carry   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a    <= A;
            op_b    <= B;
            carry_q <= Cin;
            cnt     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a    <= op_a >> CHUNK;
          op_b    <= op_b >> CHUNK;
          res_sh  <= res_next;
          carry_q <= chunk_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            Sum   <= res_next;
            Carry <= chunk_cout;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// Bench for serial_chunk_adder: five configurations run side by side on
// directed vectors, handshake corner cases, reset abort and a random sweep.
module tb_serial_chunk_adder;

  localparam int ND = 5;
  // configs: (8,1) (8,2) (8,4) (16,4) (5,5)
  int w_of[ND] = '{8, 8, 8, 16, 5};
  int n_of[ND] = '{8, 4, 2, 4, 1};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        st[ND];
  logic [15:0] ia[ND];
  logic [15:0] ib[ND];
  logic        ic[ND];
  logic        busy_o[ND];
  logic        done_o[ND];
  logic        carry_o[ND];
  logic [15:0] sum_o[ND];

  wire [7:0]  s0;
  wire [7:0]  s1;
  wire [7:0]  s2;
  wire [15:0] s3;
  wire [4:0]  s4;

  assign sum_o[0] = {8'd0, s0};
  assign sum_o[1] = {8'd0, s1};
  assign sum_o[2] = {8'd0, s2};
  assign sum_o[3] = s3;
  assign sum_o[4] = {11'd0, s4};

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .A(ia[0][7:0]), .B(ib[0][7:0]), .Cin(ic[0]),
    .busy(busy_o[0]), .done(done_o[0]), .Sum(s0), .Carry(carry_o[0]));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .A(ia[1][7:0]), .B(ib[1][7:0]), .Cin(ic[1]),
    .busy(busy_o[1]), .done(done_o[1]), .Sum(s1), .Carry(carry_o[1]));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .A(ia[2][7:0]), .B(ib[2][7:0]), .Cin(ic[2]),
    .busy(busy_o[2]), .done(done_o[2]), .Sum(s2), .Carry(carry_o[2]));
  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .A(ia[3]), .B(ib[3]), .Cin(ic[3]),
    .busy(busy_o[3]), .done(done_o[3]), .Sum(s3), .Carry(carry_o[3]));
  serial_chunk_adder #(.WIDTH(5), .CHUNK(5)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(st[4]), .A(ia[4][4:0]), .B(ib[4][4:0]), .Cin(ic[4]),
    .busy(busy_o[4]), .done(done_o[4]), .Sum(s4), .Carry(carry_o[4]));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [8:0]  exp8;   // hand-computed {Carry,Sum} for the 8-bit configs
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: exact (w+1)-bit sum of the low w bits of each operand plus carry-in.
  function automatic logic [16:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [16:0] m;
    m = (17'd1 << w) - 17'd1;
    return (17'(a) & m) + (17'(b) & m) + 17'(cin);
  endfunction

  function automatic logic [16:0] result_of(input int d);
    return 17'(sum_o[d]) | (17'(carry_o[d]) << w_of[d]);
  endfunction

  // Must be entered just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [ND-1:0] mask, input logic [15:0] a,
                        input logic [15:0] b, input logic cin, input bit mid_start,
                        input bit use_exp8, input logic [8:0] exp8);
    int          busy_cnt[ND];
    int          done_cnt[ND];
    int          done_at[ND];
    logic [16:0] got[ND];
    logic [16:0] prev[ND];
    logic [16:0] exp;
    bit          hold_ok[ND];
    for (int d = 0; d < ND; d++) begin
      busy_cnt[d] = 0;
      done_cnt[d] = 0;
      done_at[d]  = -1;
      got[d]      = '0;
      hold_ok[d]  = 1'b1;
      prev[d]     = result_of(d);
      if (mask[d]) begin
        ia[d] = a;
        ib[d] = b;
        ic[d] = cin;
        st[d] = 1'b1;
      end
    end
    @(negedge clk);
    for (int j = 0; j < 20; j++) begin
      for (int d = 0; d < ND; d++) begin
        if (mask[d] && mid_start && j == 0) begin
          st[d] = 1'b1;
          ia[d] = 16'h0001;
          ib[d] = 16'h0001;
          ic[d] = 1'b0;
        end else begin
          st[d] = 1'b0;
        end
        if (mask[d]) begin
          if (busy_o[d]) begin
            busy_cnt[d]++;
            if (result_of(d) !== prev[d]) hold_ok[d] = 1'b0;
          end
          if (done_o[d]) begin
            done_cnt[d]++;
            done_at[d] = j;
            got[d]     = result_of(d);
            if (busy_o[d]) hold_ok[d] = 1'b0;
          end
        end
      end
      @(negedge clk);
    end
    for (int d = 0; d < ND; d++) begin
      if (mask[d]) begin
        exp = (use_exp8 && w_of[d] == 8) ? {8'd0, exp8} : model(w_of[d], a, b, cin);
        chk($sformatf("%s d%0d result", tag, d), 32'(got[d]), 32'(exp));
        chk($sformatf("%s d%0d done_count", tag, d), 32'(done_cnt[d]), 32'd1);
        chk($sformatf("%s d%0d done_cycle", tag, d), 32'(done_at[d]), 32'(n_of[d]));
        chk($sformatf("%s d%0d busy_cycles", tag, d), 32'(busy_cnt[d]), 32'(n_of[d]));
        chk($sformatf("%s d%0d hold_prev", tag, d), 32'(hold_ok[d]), 32'd1);
      end
    end
  endtask

  // Back-to-back on one config: a start held high in the DONE cycle is taken at once.
  task automatic back_to_back(input int d);
    int k;
    ia[d] = 16'h003C;
    ib[d] = 16'h0047;
    ic[d] = 1'b0;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    k = 0;
    while (!done_o[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("b2b d%0d first_done_seen", d), 32'(done_o[d]), 32'd1);
    chk($sformatf("b2b d%0d first_latency", d), 32'(k), 32'(n_of[d]));
    chk($sformatf("b2b d%0d first_result", d), 32'(result_of(d)), 32'h083);
    ia[d] = 16'h0010;
    ib[d] = 16'h0020;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    chk($sformatf("b2b d%0d no_gap_busy", d), 32'(busy_o[d]), 32'd1);
    chk($sformatf("b2b d%0d no_gap_done", d), 32'(done_o[d]), 32'd0);
    k = 0;
    while (!done_o[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("b2b d%0d second_latency", d), 32'(k), 32'(n_of[d]));
    chk($sformatf("b2b d%0d second_result", d), 32'(result_of(d)), 32'h030);
    @(negedge clk);
  endtask

  initial begin
    int dones;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rc;

    vt[0] = '{a: 16'h00FF, b: 16'h0001, cin: 1'b0, exp8: 9'h100};
    vt[1] = '{a: 16'hA5A5, b: 16'h5A5A, cin: 1'b1, exp8: 9'h100};
    vt[2] = '{a: 16'h123C, b: 16'h0047, cin: 1'b0, exp8: 9'h083};
    vt[3] = '{a: 16'h8080, b: 16'h8080, cin: 1'b0, exp8: 9'h100};
    vt[4] = '{a: 16'h0000, b: 16'h0000, cin: 1'b0, exp8: 9'h000};
    vt[5] = '{a: 16'hFFFF, b: 16'hFFFF, cin: 1'b1, exp8: 9'h1FF};
    vt[6] = '{a: 16'h0010, b: 16'h0020, cin: 1'b0, exp8: 9'h030};

    rst_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      st[d] = 1'b0;
      ia[d] = '0;
      ib[d] = '0;
      ic[d] = 1'b0;
    end

    // Reset applied before any clock edge must clear outputs on its own.
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("reset d%0d busy", d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("reset d%0d done", d), 32'(done_o[d]), 32'd0);
      chk($sformatf("reset d%0d result", d), 32'(result_of(d)), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++)
      run_op($sformatf("vec%0d", v), 5'b11111, vt[v].a, vt[v].b, vt[v].cin, 1'b0, 1'b1, vt[v].exp8);

    // Start and new operands during the run must not disturb the result.
    run_op("ignore", 5'b11111, 16'h003C, 16'h0047, 1'b0, 1'b1, 1'b1, 9'h083);

    back_to_back(0);
    back_to_back(2);

    // Abort mid-run with an asynchronous reset between edges.
    for (int d = 0; d < ND; d++) begin
      ia[d] = 16'h5555;
      ib[d] = 16'h1111;
      ic[d] = 1'b1;
      st[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) st[d] = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("abort d%0d busy", d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("abort d%0d done", d), 32'(done_o[d]), 32'd0);
      chk($sformatf("abort d%0d result", d), 32'(result_of(d)), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int j = 0; j < 12; j++) begin
      for (int d = 0; d < ND; d++)
        if (done_o[d] || busy_o[d]) dones++;
      @(negedge clk);
    end
    chk("abort no_done_after", 32'(dones), 32'd0);

    run_op("post_abort", 5'b11111, 16'h0080, 16'h0080, 1'b0, 1'b0, 1'b1, 9'h100);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = $urandom;
      run_op($sformatf("rnd%0d", i), 5'b11111, ra, rb, rc[0], 1'b0, 1'b0, 9'h000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
